// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
//   Pixel timebase for the VGA output path. Divides the system clock into a
//   one-clock pixel enable, steps horizontal/vertical counters on that enable
//   and produces sync, blanking, coordinate and line/frame strobes, all in the
//   clk_in domain.
//
//   Ports
//     clk_in       system clock
//     reset_n      asynchronous active-low reset
//     enable       run request; low stops and clears the timing
//     pix_tick     one-clock pixel enable (last clock of each pixel)
//     hsync/vsync  active-low syncs (registered)
//     video_on     current (x,y) lies in the active area (registered)
//     x/y          current horizontal/vertical count
//     line_start   pix_tick on the first pixel of a line
//     frame_start  line_start on line 0
//
//   Handshake: there is no valid/ready pair; enable is a level request that is
//   sampled on every clock edge, and pix_tick qualifies x/y for exactly one
//   clock out of every DIVISOR.
module vga_timing_ctrl #(
  parameter int DIVISOR  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int COORD_W  = 10
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               enable,
  output logic               pix_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DIVISOR - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);

  typedef enum logic [0:0] {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [COORD_W-1:0] hcount_q, hcount_d;
  logic [COORD_W-1:0] vcount_q, vcount_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               video_on_q, video_on_d;

  logic tick;
  logic run_d;

  // With DIVISOR=1 the divider is a constant 0 that always equals DIV_LAST,
  // so the tick stays high for as long as the block runs.
  assign tick = (state_q == ST_RUNNING) && (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;

    if (!enable) begin
      // Stop takes priority over any wrap happening in the same cycle.
      state_d   = ST_STOPPED;
      div_cnt_d = '0;
      hcount_d  = '0;
      vcount_d  = '0;
    end else if (state_q == ST_STOPPED) begin
      // Start at (0,0) with the divider at its first phase.
      state_d   = ST_RUNNING;
      div_cnt_d = '0;
      hcount_d  = '0;
      vcount_d  = '0;
    end else if (tick) begin
      div_cnt_d = '0;
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + COORD_W'(1);
      end else begin
        hcount_d = hcount_q + COORD_W'(1);
      end
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    // Decodes use the next-state counters so the registered outputs change
    // on the same edge as x/y.
    run_d      = (state_d == ST_RUNNING);
    video_on_d = run_d && (int'(hcount_d) < H_ACTIVE) && (int'(vcount_d) < V_ACTIVE);
    hsync_d    = !(run_d && (int'(hcount_d) >= HS_START) && (int'(hcount_d) < HS_END));
    vsync_d    = !(run_d && (int'(vcount_d) >= VS_START) && (int'(vcount_d) < VS_END));
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_STOPPED;
      div_cnt_q  <= '0;
      hcount_q   <= '0;
      vcount_q   <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      hcount_q   <= hcount_d;
      vcount_q   <= vcount_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

  assign pix_tick    = tick;
  assign line_start  = tick && (hcount_q == '0);
  assign frame_start = tick && (hcount_q == '0) && (vcount_q == '0);
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign x           = hcount_q;
  assign y           = vcount_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl
//   Three instances share clock and reset: the default 640x480 timing, a
//   medium configuration short enough to cover whole frames, and a tiny
//   DIVISOR=1 configuration. A reference model derives every output from the
//   number of clocks since the run started; directed steps cover startup,
//   horizontal/vertical timing, stops and asynchronous reset.
module tb_vga_timing_ctrl;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic en_def, en_mid, en_sml;

  logic       d_tick, d_hs, d_vs, d_von, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       m_tick, m_hs, m_vs, m_von, m_ls, m_fs;
  logic [9:0] m_x, m_y;
  logic       s_tick, s_hs, s_vs, s_von, s_ls, s_fs;
  logic [9:0] s_x, s_y;

  vga_timing_ctrl u_def (
    .clk_in(clk_in), .reset_n(reset_n), .enable(en_def),
    .pix_tick(d_tick), .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
    .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_ctrl #(
    .DIVISOR(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .COORD_W(10)
  ) u_mid (
    .clk_in(clk_in), .reset_n(reset_n), .enable(en_mid),
    .pix_tick(m_tick), .hsync(m_hs), .vsync(m_vs), .video_on(m_von),
    .x(m_x), .y(m_y), .line_start(m_ls), .frame_start(m_fs)
  );

  vga_timing_ctrl #(
    .DIVISOR(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .COORD_W(10)
  ) u_sml (
    .clk_in(clk_in), .reset_n(reset_n), .enable(en_sml),
    .pix_tick(s_tick), .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
    .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
  );

  logic [25:0] obs_def, obs_mid, obs_sml;
  assign obs_def = {d_tick, d_hs, d_vs, d_von, d_ls, d_fs, d_x, d_y};
  assign obs_mid = {m_tick, m_hs, m_vs, m_von, m_ls, m_fs, m_x, m_y};
  assign obs_sml = {s_tick, s_hs, s_vs, s_von, s_ls, s_fs, s_x, s_y};

  // ---------------- scoring ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Output vector for the clock that is t clocks into a run (t=0 is the
  // clock right after the enable-sampling edge).
  function automatic logic [25:0] model(input int dv, input int ha, input int hf,
                                        input int hs, input int hb, input int va,
                                        input int vf, input int vs, input int vb,
                                        input int t, input bit run);
    int ht, vt, p, xx, yy;
    bit tk, hsn, vsn, von, ls, fs;
    logic [9:0] xv, yv;
    if (!run) return {1'b0, 1'b1, 1'b1, 3'b000, 20'd0};
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    p   = t / dv;
    xx  = p % ht;
    yy  = (p / ht) % vt;
    tk  = (t % dv) == dv - 1;
    hsn = !(xx >= ha + hf && xx < ha + hf + hs);
    vsn = !(yy >= va + vf && yy < va + vf + vs);
    von = (xx < ha) && (yy < va);
    ls  = tk && (xx == 0);
    fs  = ls && (yy == 0);
    xv  = xx[9:0];
    yv  = yy[9:0];
    return {tk, hsn, vsn, von, ls, fs, xv, yv};
  endfunction

  bit run_def, run_mid, run_sml;
  int t_def, t_mid, t_sml;

  always @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      run_def <= 1'b0; run_mid <= 1'b0; run_sml <= 1'b0;
      t_def <= 0; t_mid <= 0; t_sml <= 0;
    end else begin
      if (en_def) begin t_def <= run_def ? t_def + 1 : 0; run_def <= 1'b1; end
      else run_def <= 1'b0;
      if (en_mid) begin t_mid <= run_mid ? t_mid + 1 : 0; run_mid <= 1'b1; end
      else run_mid <= 1'b0;
      if (en_sml) begin t_sml <= run_sml ? t_sml + 1 : 0; run_sml <= 1'b1; end
      else run_sml <= 1'b0;
    end
  end

  bit auto_on = 1'b0;
  always @(negedge clk_in) begin
    if (auto_on) begin
      check("model_def", obs_def, model(2, 640, 16, 96, 48, 480, 10, 2, 33, t_def, run_def));
      check("model_mid", obs_mid, model(2, 16, 2, 3, 2, 6, 2, 2, 3, t_mid, run_mid));
      check("model_sml", obs_sml, model(1, 4, 1, 1, 1, 2, 1, 1, 1, t_sml, run_sml));
    end
  end

  // ---------------- directed / random sequence ----------------
  initial begin
    int n, t0, fs_def_n, fs_mid_n, fs_sml_n, maxx, maxy;
    logic [9:0] fx, fy;
    logic fvon, tick_all;
    logic [25:0] stopped_vec;
    stopped_vec = {1'b0, 1'b1, 1'b1, 3'b000, 20'd0};

    en_def = 1'b1; en_mid = 1'b1; en_sml = 1'b1;
    auto_on = 1'b1;

    // Reset held with enable high.
    repeat (3) @(negedge clk_in);
    check("rst_hsync", d_hs, 1);
    check("rst_vsync", d_vs, 1);
    check("rst_video_on", d_von, 0);
    check("rst_xy", {d_x, d_y}, 0);

    // Release; next posedge is the enable-sampling edge.
    reset_n = 1'b1;
    @(posedge clk_in);
    fs_def_n = 0; fs_mid_n = 0; fs_sml_n = 0;
    fx = '1; fy = '1; fvon = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_in);
      if (d_fs && fs_def_n == 0) begin fs_def_n = i; fx = d_x; fy = d_y; fvon = d_von; end
      if (m_fs && fs_mid_n == 0) fs_mid_n = i;
      if (s_fs && fs_sml_n == 0) fs_sml_n = i;
    end
    check("start_fs_def", fs_def_n, 2);
    check("start_fs_mid", fs_mid_n, 2);
    check("start_fs_sml", fs_sml_n, 1);
    check("start_xy", {fx, fy}, 0);
    check("start_video_on", fvon, 1);

    // Horizontal timing on the default instance.
    n = 0; while (d_x != 10'd639 && n < 4000) begin @(negedge clk_in); n++; end
    check("x639_to", n < 4000, 1);
    check("von_at_639", d_von, 1);
    n = 0; while (d_x != 10'd640 && n < 4000) begin @(negedge clk_in); n++; end
    check("von_at_640", d_von, 0);
    n = 0; while (d_hs != 1'b0 && n < 4000) begin @(negedge clk_in); n++; end
    check("hs_fall_to", n < 4000, 1);
    check("hs_fall_x", d_x, 656);
    t0 = cyc;
    n = 0; while (d_hs != 1'b1 && n < 4000) begin @(negedge clk_in); n++; end
    check("hs_width", cyc - t0, 192);
    n = 0; while (!d_ls && n < 4000) begin @(negedge clk_in); n++; end
    t0 = cyc;
    @(negedge clk_in);
    n = 0; while (!d_ls && n < 4000) begin @(negedge clk_in); n++; end
    check("line_period", cyc - t0, 1600);

    // Vertical timing on the medium instance (H_TOTAL=23, V_TOTAL=13).
    n = 0; while (m_vs != 1'b0 && n < 2000) begin @(negedge clk_in); n++; end
    check("vs_fall_to", n < 2000, 1);
    check("vs_fall_y", m_y, 8);
    t0 = cyc;
    n = 0; while (m_vs != 1'b1 && n < 2000) begin @(negedge clk_in); n++; end
    check("vs_width", cyc - t0, 92);
    check("vs_rise_y", m_y, 10);
    n = 0; while (!m_fs && n < 2000) begin @(negedge clk_in); n++; end
    t0 = cyc;
    @(negedge clk_in);
    n = 0; while (!m_fs && n < 2000) begin @(negedge clk_in); n++; end
    check("frame_period_mid", cyc - t0, 598);
    n = 0; while (m_y != 10'd12 && n < 2000) begin @(negedge clk_in); n++; end
    n = 0; while (m_y == 10'd12 && n < 2000) begin @(negedge clk_in); n++; end
    check("y_wrap", m_y, 0);

    // Tiny DIVISOR=1 instance: one full frame.
    n = 0; while (!s_fs && n < 200) begin @(negedge clk_in); n++; end
    t0 = cyc; maxx = 0; maxy = 0; tick_all = 1'b1;
    @(negedge clk_in);
    n = 0;
    while (!s_fs && n < 200) begin
      if (int'(s_x) > maxx) maxx = int'(s_x);
      if (int'(s_y) > maxy) maxy = int'(s_y);
      tick_all = tick_all & s_tick;
      @(negedge clk_in); n++;
    end
    check("sml_frame", cyc - t0, 35);
    check("sml_maxx", maxx, 6);
    check("sml_maxy", maxy, 4);
    check("sml_tick_const", tick_all, 1);

    // Stop in the same cycle as the frame wrap.
    n = 0; while (!(s_x == 10'd6 && s_y == 10'd4) && n < 200) begin @(negedge clk_in); n++; end
    en_sml = 1'b0;
    @(negedge clk_in);
    check("sml_stop_wrap", obs_sml, stopped_vec);
    en_sml = 1'b1;

    // Stop the default instance mid-line, then restart.
    n = 0; while (d_x != 10'd300 && n < 4000) begin @(negedge clk_in); n++; end
    check("x300_to", n < 4000, 1);
    en_def = 1'b0;
    @(negedge clk_in);
    check("stop_state", obs_def, stopped_vec);
    en_def = 1'b1;
    fs_def_n = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_in);
      if (d_fs && fs_def_n == 0) fs_def_n = i;
    end
    check("restart_fs", fs_def_n, 2);

    // Random enable drops across the instances.
    repeat (12) begin
      int who, len;
      repeat ($urandom_range(20, 300)) @(negedge clk_in);
      who = $urandom_range(0, 2);
      len = $urandom_range(1, 4);
      if (who == 0) en_def = 1'b0; else if (who == 1) en_mid = 1'b0; else en_sml = 1'b0;
      repeat (len) @(negedge clk_in);
      en_def = 1'b1; en_mid = 1'b1; en_sml = 1'b1;
    end

    // Asynchronous reset in the middle of an hsync pulse.
    n = 0; while (d_hs != 1'b0 && n < 4000) begin @(negedge clk_in); n++; end
    check("hs_low_to", n < 4000, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_hsync", d_hs, 1);
    check("async_xy", {d_x, d_y}, 0);
    check("async_von", d_von, 0);
    @(negedge clk_in);
    check("rst_after_xy", {d_x, d_y, m_x, m_y}, 0);
    reset_n = 1'b1;
    repeat (100) @(negedge clk_in);

    auto_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
